scan_seq8: RTL and testbench

Free-running channel scanner that drives the select address `A[2:0]` and enable `EN` of the team's 3-to-8 enabled decoder. Each enabled channel gets a fixed dwell of `DIV` clocks with `EN` high, separated by `BLANK` clocks with `EN` low so the decoder outputs never overlap. Channels whose `MASK` bit is clear are skipped. The block sits directly upstream of the decoder and provides a frame-boundary pulse for display and LED multiplexing logic.

---
 rtl/scan_seq8.sv | 153 +++++++++++++++
 tb/tb_scan_seq8.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq8.sv
// scan_seq8: free-running channel scanner for a 3-to-8 enabled decoder.
// Each enabled channel gets DIV clocks with EN high, preceded by BLANK
// clocks with EN low. Channels with a clear MASK bit are skipped.
// Ports:
//   CLK    - clock, rising edge
//   RST_N  - asynchronous active-low reset
//   RUN    - scan request, sampled at decision points
//   MASK   - channel enables, sampled at decision points
//   A      - registered channel address to the decoder
//   EN     - registered decoder enable
//   FRAME  - registered one-cycle pulse when the scan wraps
//   BUSY   - high whenever the sequencer is not idle
module scan_seq8 #(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic [7:0] MASK,
  output logic [2:0] A,
  output logic       EN,
  output logic       FRAME,
  output logic       BUSY
);

  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  // Terminal counts; the counter runs 0..N-1 in each timed state.
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    (BLANK > 0) ? CW'(BLANK - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ACTIVE
  } state_e;

  // With no blanking, a new dwell starts straight in ACTIVE.
  localparam state_e S_ENTRY =
    (BLANK == 0) ? S_ACTIVE : S_BLANK;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    a_q, a_d;
  logic          en_q, en_d;
  logic          frame_q, frame_d;

  logic [7:0]    mask_hi;
  logic          mask_any;
  logic          hi_any;
  logic [2:0]    first_ch;
  logic [2:0]    next_ch;
  logic          blk_done;
  logic          div_done;

  function automatic logic [2:0] low_bit(
    input logic [7:0] m
  );
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Channel search: lowest set bit overall, and
  // lowest set bit strictly above the current address.
  always_comb begin
    mask_hi  = MASK & (8'hFE << a_q);
    mask_any = |MASK;
    hi_any   = |mask_hi;
    first_ch = low_bit(MASK);
    next_ch  = low_bit(mask_hi);
  end

  always_comb begin
    blk_done = (cnt_q == BLK_LAST);
    div_done = (cnt_q == DIV_LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    frame_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (RUN && mask_any) begin
          a_d     = first_ch;
          state_d = S_ENTRY;
        end
      end
      S_BLANK: begin
        if (blk_done) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (div_done) begin
          cnt_d = '0;
          if (!RUN || !mask_any) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ENTRY;
            if (hi_any) begin
              a_d = next_ch;
            end else begin
              a_d     = first_ch;
              frame_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      en_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      en_q    <= en_d;
      frame_q <= frame_d;
    end
  end

  assign A     = a_q;
  assign EN    = en_q;
  assign FRAME = frame_q;
  assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_scan_seq8.sv
// tb_scan_seq8: self-checking bench for scan_seq8.
// Dwell scoreboard, table-driven scans, stop/reset/maximum-count cases.
module tb_scan_seq8;

  typedef struct {
    int ch;
    int dl;
    int gap;
    int fc;
  } rec_t;

  typedef struct {
    int         inst;
    logic [7:0] mask;
    int         first;
    int         period;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run0 = 0, run1 = 0, run2 = 0, run3 = 0;
  logic [7:0] mask0 = 0, mask1 = 0, mask2 = 0, mask3 = 0;
  logic [2:0] a0, a1, a2, a3;
  logic       en0, en1, en2, en3;
  logic       fr0, fr1, fr2, fr3;
  logic       bz0, bz1, bz2, bz3;

  int n_chk = 0;
  int n_fail = 0;

  rec_t exp_q[$];
  int   fstamp[$];
  bit   mon_en = 0;
  int   sel = 0;
  int   cyc = 0;
  bit   act = 0;
  int   cur_a, dl, cur_gap, cur_fc;
  int   gap = 0;
  int   fc = 0;

  always #5 clk = ~clk;

  scan_seq8 #(.DIV(4), .BLANK(1)) u0 (
    .CLK(clk), .RST_N(rst_n), .RUN(run0), .MASK(mask0),
    .A(a0), .EN(en0), .FRAME(fr0), .BUSY(bz0)
  );
  scan_seq8 #(.DIV(1), .BLANK(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .RUN(run1), .MASK(mask1),
    .A(a1), .EN(en1), .FRAME(fr1), .BUSY(bz1)
  );
  scan_seq8 #(.DIV(65535), .BLANK(65535)) u2 (
    .CLK(clk), .RST_N(rst_n), .RUN(run2), .MASK(mask2),
    .A(a2), .EN(en2), .FRAME(fr2), .BUSY(bz2)
  );
  scan_seq8 #(.DIV(65535), .BLANK(0)) u3 (
    .CLK(clk), .RST_N(rst_n), .RUN(run3), .MASK(mask3),
    .A(a3), .EN(en3), .FRAME(fr3), .BUSY(bz3)
  );

  task automatic chk(input string nm, input int act_v,
                     input int exp_v);
    n_chk++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act_v, exp_v);
    end
  endtask

  task automatic emit();
    rec_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL dwell_unexpected: got ch %0d len %0d expected none",
               cur_a, dl);
    end else begin
      e = exp_q.pop_front();
      chk("dwell_ch", cur_a, e.ch);
      chk("dwell_len", dl, e.dl);
      chk("dwell_gap", cur_gap, e.gap);
      chk("dwell_frame", cur_fc, e.fc);
    end
  endtask

  // Dwell monitor: turns the EN/A/FRAME stream of the selected
  // instance into {channel, length, preceding gap, frames} records.
  always @(negedge clk) begin : mon
    logic       m_en, m_fr, m_bz;
    logic [2:0] m_a;
    m_en = (sel == 1) ? en1 : en0;
    m_fr = (sel == 1) ? fr1 : fr0;
    m_bz = (sel == 1) ? bz1 : bz0;
    m_a  = (sel == 1) ? a1 : a0;
    cyc  = cyc + 1;
    if (!mon_en) begin
      act = 0;
      gap = 0;
      fc  = 0;
    end else if (m_en && (!act || int'(m_a) != cur_a || m_fr)) begin
      if (act) emit();
      act     = 1;
      cur_a   = int'(m_a);
      dl      = 1;
      cur_gap = gap;
      cur_fc  = fc + int'(m_fr);
      gap     = 0;
      fc      = 0;
      if (m_fr) fstamp.push_back(cyc);
    end else if (m_en) begin
      dl++;
      if (m_fr) begin
        cur_fc++;
        fstamp.push_back(cyc);
      end
    end else begin
      if (act) begin
        emit();
        act = 0;
      end
      if (m_fr) begin
        fc++;
        fstamp.push_back(cyc);
      end
      if (m_bz) gap++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r,
                       input logic [7:0] m);
    if (i == 1) begin
      run1 = r;
      mask1 = m;
    end else begin
      run0 = r;
      mask0 = m;
    end
  endtask

  task automatic set_run(input int i, input logic r);
    if (i == 1) run1 = r;
    else run0 = r;
  endtask

  function automatic int o_a(input int i);
    return (i == 1) ? int'(a1) : int'(a0);
  endfunction
  function automatic int o_en(input int i);
    return (i == 1) ? int'(en1) : int'(en0);
  endfunction
  function automatic int o_fr(input int i);
    return (i == 1) ? int'(fr1) : int'(fr0);
  endfunction
  function automatic int o_bz(input int i);
    return (i == 1) ? int'(bz1) : int'(bz0);
  endfunction

  task automatic wait_q(input int n, input int budget,
                        input string nm);
    int t;
    t = 0;
    while (exp_q.size() > n && t < budget) begin
      tick();
      t++;
    end
    chk(nm, int'(exp_q.size() <= n), 1);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int t;
    t = 0;
    while ((o_bz(i) != 0 || exp_q.size() != 0) && t < budget) begin
      tick();
      t++;
    end
    chk("idle_busy", o_bz(i), 0);
    chk("idle_drained", exp_q.size(), 0);
  endtask

  vec_t tv[7];

  initial begin
    int   chans[$];
    vec_t v;
    int   n, dv, bl, kk, nfr, t, anyb;
    int   m_blank, m_rise, m_en, m_abad;
    int   d_a0, d_step, d_enlo, d_fr;

    tv[0] = '{0, 8'hFF, 0, 40};
    tv[1] = '{0, 8'hA4, 2, 15};
    tv[2] = '{0, 8'h01, 0, 5};
    tv[3] = '{0, 8'h80, 7, 5};
    tv[4] = '{0, 8'h81, 0, 10};
    tv[5] = '{1, 8'hFF, 0, 8};
    tv[6] = '{1, 8'h24, 2, 2};

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_a", int'(a0), 0);
    chk("rst_en", int'(en0), 0);
    chk("rst_frame", int'(fr0), 0);
    chk("rst_busy", int'(bz0), 0);
    rst_n = 1'b1;
    tick();

    // RUN with an empty mask must not leave IDLE.
    drive(0, 1'b1, 8'h00);
    anyb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      anyb = anyb | int'(bz0);
    end
    chk("empty_mask_busy", anyb, 0);
    drive(0, 1'b0, 8'h00);
    tick();

    for (int r = 0; r < 7; r++) begin
      v = tv[r];
      dv = (v.inst == 1) ? 1 : 4;
      bl = (v.inst == 1) ? 0 : 1;
      chans.delete();
      for (int i = 0; i < 8; i++) begin
        if (v.mask[i]) chans.push_back(i);
      end
      kk = chans.size();
      n = 2 * kk + 2;
      nfr = 0;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back('{chans[j % kk], dv, bl,
                          (j > 0 && j % kk == 0) ? 1 : 0});
        if (j > 0 && j % kk == 0) nfr++;
      end
      sel = v.inst;
      fstamp.delete();
      mon_en = 1;
      drive(v.inst, 1'b1, v.mask);
      tick();
      chk("start_busy", o_bz(v.inst), 1);
      chk("start_a", o_a(v.inst), v.first);
      chk("start_en", o_en(v.inst), (bl == 0) ? 1 : 0);
      wait_q(1, 600, "scan_progress");
      set_run(v.inst, 1'b0);
      wait_idle(v.inst, 50);
      chk("stop_a", o_a(v.inst), chans[(n - 1) % kk]);
      chk("stop_frame", o_fr(v.inst), 0);
      chk("frame_count", fstamp.size(), nfr);
      chk("frame_period",
          (fstamp.size() >= 2) ? fstamp[$] - fstamp[$ - 1] : -1,
          v.period);
      tick();
    end

    // Mask shrinks to channel 0 while channel 5 is dwelling.
    sel = 0;
    fstamp.delete();
    exp_q.push_back('{2, 4, 1, 0});
    exp_q.push_back('{5, 4, 1, 0});
    exp_q.push_back('{0, 4, 1, 1});
    exp_q.push_back('{0, 4, 1, 1});
    exp_q.push_back('{0, 4, 1, 1});
    drive(0, 1'b1, 8'hA4);
    t = 0;
    while (!(en0 && a0 == 3'd5) && t < 60) begin
      tick();
      t++;
    end
    chk("reach_ch5", int'(a0), 5);
    mask0 = 8'h01;
    wait_q(1, 100, "maskchg_progress");
    run0 = 1'b0;
    wait_idle(0, 50);
    chk("maskchg_frames", fstamp.size(), 3);
    chk("maskchg_period",
        (fstamp.size() >= 2) ? fstamp[$] - fstamp[$ - 1] : -1, 5);
    tick();

    // RUN drops after two EN cycles on channel 3.
    fstamp.delete();
    exp_q.push_back('{3, 4, 1, 0});
    drive(0, 1'b1, 8'h08);
    t = 0;
    while (!en0 && t < 10) begin
      tick();
      t++;
    end
    tick();
    chk("stop_en2", int'(en0), 1);
    run0 = 1'b0;
    tick();
    chk("stop_en3", int'(en0), 1);
    tick();
    chk("stop_en4", int'(en0), 1);
    chk("stop_busy4", int'(bz0), 1);
    tick();
    chk("stop_en_off", int'(en0), 0);
    chk("stop_busy_off", int'(bz0), 0);
    chk("stop_hold_a", int'(a0), 3);
    chk("stop_no_frame", fstamp.size(), 0);
    wait_idle(0, 10);

    // Asynchronous reset in the middle of a dwell.
    mon_en = 0;
    tick();
    drive(0, 1'b1, 8'hFF);
    t = 0;
    while (!(en0 && a0 == 3'd3) && t < 60) begin
      tick();
      t++;
    end
    chk("reach_ch3", int'(a0), 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", int'(a0), 0);
    chk("async_rst_en", int'(en0), 0);
    chk("async_rst_frame", int'(fr0), 0);
    chk("async_rst_busy", int'(bz0), 0);
    run0 = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_busy", int'(bz0), 0);
    chk("post_rst_en", int'(en0), 0);
    chk("post_rst_a", int'(a0), 0);

    // Maximum counts: 65535 blank on u2, 65535 dwell on u3.
    mask2 = 8'h81;
    mask3 = 8'h03;
    run2 = 1'b1;
    run3 = 1'b1;
    m_blank = 0;
    m_rise = -1;
    m_en = 0;
    m_abad = 0;
    d_a0 = 0;
    d_step = -1;
    d_enlo = 0;
    d_fr = 0;
    for (int k = 0; k < 65546; k++) begin
      tick();
      if (bz2 && !en2) m_blank++;
      if (en2) m_en++;
      if (en2 && m_rise < 0) m_rise = k;
      if (a2 != 3'd0) m_abad++;
      if (en3 && a3 == 3'd0) d_a0++;
      if (a3 == 3'd1 && d_step < 0) d_step = k;
      if (!en3) d_enlo++;
      if (fr3 || fr2) d_fr++;
    end
    chk("max_blank_len", m_blank, 65535);
    chk("max_en_rise", m_rise, 65535);
    chk("max_en_cycles", m_en, 11);
    chk("max_a_hold", m_abad, 0);
    chk("max_dwell_len", d_a0, 65535);
    chk("max_dwell_step", d_step, 65535);
    chk("max_en_gapless", d_enlo, 0);
    chk("max_no_frame", d_fr, 0);
    run2 = 1'b0;
    run3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
